// File: rtl/pong_saida.sv
// Avalon-MM output port driving eight Pong outputs, with data/set/clear access
// and an optional pulse timer compiled in when PONG_SAIDA_PULSE_EN is defined.
module pong_saida #(
   parameter logic [7:0] RESET_VALUE = 8'h00
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  out_port
);

   logic        wr_s;
   logic [7:0]  overlay_s;
   logic        unused_s;
   logic [7:0]  data_q, data_d;
   logic [7:0]  out_port_q, out_port_d;
   logic [31:0] readdata_q, readdata_d;
`ifdef PONG_SAIDA_PULSE_EN
   logic [7:0]  mask_q, mask_d;
   logic [15:0] remaining_q, remaining_d;
`endif

   assign unused_s = ^writedata[31:8];
   assign readdata = readdata_q;
   assign out_port = out_port_q;

   // Next-state for data register, pulse timer, port output and read mux.
   always_comb begin
      wr_s       = chipselect & ~write_n;
      data_d     = data_q;
      readdata_d = 32'h0000_0000;
      if (wr_s) begin
         case (address)
            2'd0:    data_d = writedata[7:0];
            2'd1:    data_d = data_q | writedata[7:0];
            2'd2:    data_d = data_q & ~writedata[7:0];
            default: data_d = data_q;
         endcase
      end else begin
         data_d = data_q;
      end
`ifdef PONG_SAIDA_PULSE_EN
      mask_d      = mask_q;
      remaining_d = remaining_q;
      if (wr_s && (address == 2'd3)) begin
         mask_d      = writedata[7:0];
         remaining_d = writedata[23:8];
      end else if (remaining_q != 16'd0) begin
         remaining_d = remaining_q - 16'd1;
      end else begin
         remaining_d = remaining_q;
      end
      overlay_s = (remaining_d != 16'd0) ? mask_d : 8'h00;
`else
      overlay_s = 8'h00;
`endif
      out_port_d = data_d | overlay_s;
      // Reads return the state held before this edge.
      case (address)
         2'd0:    readdata_d = {24'h00_0000, data_q};
`ifdef PONG_SAIDA_PULSE_EN
         2'd3:    readdata_d = {(remaining_q != 16'd0), 7'h00, remaining_q, mask_q};
`endif
         default: readdata_d = 32'h0000_0000;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q      <= RESET_VALUE;
         out_port_q  <= RESET_VALUE;
         readdata_q  <= 32'h0000_0000;
`ifdef PONG_SAIDA_PULSE_EN
         mask_q      <= 8'h00;
         remaining_q <= 16'd0;
`endif
      end else begin
         data_q      <= data_d;
         out_port_q  <= out_port_d;
         readdata_q  <= readdata_d;
`ifdef PONG_SAIDA_PULSE_EN
         mask_q      <= mask_d;
         remaining_q <= remaining_d;
`endif
      end
   end

endmodule

// File: tb/tb_pong_saida.sv
// Self-checking bench for pong_saida: directed literal checks plus random
// traffic compared every cycle against a cycle-stamped behavioural model.
module tb_pong_saida;

   localparam logic [7:0] RV = 8'hA5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int checks = 0;
   int errors = 0;

   // Model: pulse described by its end cycle instead of a down-counter.
   int          cyc = 0;
   int          pend = 0;
   logic [7:0]  m_data = 8'h00;
   logic [7:0]  m_mask = 8'h00;
   logic [7:0]  exp_out = 8'h00;
   logic [31:0] exp_rd = 32'h0;
   bit          m_valid = 1'b0;

`ifdef PONG_SAIDA_PULSE_EN
   localparam bit PULSE = 1'b1;
`else
   localparam bit PULSE = 1'b0;
`endif

   pong_saida #(.RESET_VALUE(RV)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model update at each rising edge.
   always @(posedge clk) begin
      int rem_old;
      cyc = cyc + 1;
      rem_old = (pend > cyc - 1) ? pend - (cyc - 1) : 0;
      if (!reset_n) begin
         m_data = RV; m_mask = 8'h00; pend = 0; exp_rd = 32'h0; m_valid = 1'b1;
      end else begin
         if (address == 2'd0) exp_rd = {24'h0, m_data};
         else if (address == 2'd3 && PULSE)
            exp_rd = {(rem_old != 0), 7'h00, 16'(rem_old), m_mask};
         else exp_rd = 32'h0;
         if (chipselect && !write_n) begin
            if (address == 2'd0) m_data = writedata[7:0];
            else if (address == 2'd1) m_data = m_data | writedata[7:0];
            else if (address == 2'd2) m_data = m_data & ~writedata[7:0];
            else if (PULSE) begin
               m_mask = writedata[7:0];
               pend = cyc + int'(writedata[23:8]);
            end
         end
      end
      exp_out = m_data | ((pend > cyc) ? m_mask : 8'h00);
   end

   // Compare process: DUT against model on every cycle after the first reset.
   always @(negedge clk) begin
      if (m_valid) begin
         check("out_port", {24'h0, out_port}, {24'h0, exp_out});
         check("readdata", readdata, exp_rd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic idle(input logic [1:0] a);
      address = a; chipselect = 1'b0; write_n = 1'b1;
      tick();
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
      tick();
      check("reset_out", {24'h0, out_port}, 32'h0000_00A5);
      check("reset_rd", readdata, 32'h0);
      check("model_reset", {24'h0, exp_out}, 32'h0000_00A5);
      reset_n = 1'b1;
      idle(2'd0);
      check("read_addr0", readdata, 32'h0000_00A5);
      wr(2'd0, 32'h0000_000F); check("write_data", {24'h0, out_port}, 32'h0F);
      wr(2'd1, 32'h0000_00C0); check("write_set", {24'h0, out_port}, 32'hCF);
      wr(2'd2, 32'h0000_0003); check("write_clr", {24'h0, out_port}, 32'hCC);
      check("model_clr", {24'h0, exp_out}, 32'hCC);
`ifdef PONG_SAIDA_PULSE_EN
      wr(2'd0, 32'h0);
      wr(2'd3, 32'h0000_0310); check("pulse_c1", {24'h0, out_port}, 32'h10);
      idle(2'd3);              check("pulse_c2", {24'h0, out_port}, 32'h10);
      check("pulse_read", readdata, 32'h8000_0310);
      idle(2'd0);              check("pulse_c3", {24'h0, out_port}, 32'h10);
      idle(2'd0);              check("pulse_end", {24'h0, out_port}, 32'h00);
      wr(2'd3, 32'h0000_0A01); check("restart_a", {24'h0, out_port}, 32'h01);
      idle(2'd0); idle(2'd0); idle(2'd0);
      check("restart_b", {24'h0, out_port}, 32'h01);
      wr(2'd3, 32'h0000_0202); check("restart_c", {24'h0, out_port}, 32'h02);
      idle(2'd0);              check("restart_d", {24'h0, out_port}, 32'h02);
      idle(2'd0);              check("restart_end", {24'h0, out_port}, 32'h00);
      wr(2'd3, 32'h0000_0A04); check("cancel_a", {24'h0, out_port}, 32'h04);
      wr(2'd3, 32'h0000_0000); check("cancel_b", {24'h0, out_port}, 32'h00);
      wr(2'd3, 32'h0000_1408);
      reset_n = 1'b0; idle(2'd3);
      check("rst_mid_out", {24'h0, out_port}, 32'hA5);
      reset_n = 1'b1; idle(2'd3);
      check("rst_mid_rd", readdata, 32'h0);
      check("rst_mid_ovl", {24'h0, out_port}, 32'hA5);
      wr(2'd3, 32'h0000_0240); check("exp_set_a", {24'h0, out_port}, 32'hE5);
      idle(2'd0);
      wr(2'd1, 32'h0000_0002); check("exp_set_b", {24'h0, out_port}, 32'hA7);
`else
      wr(2'd3, 32'h00FF_FFFF); check("nopulse_out", {24'h0, out_port}, 32'hCC);
      idle(2'd3);              check("nopulse_rd", readdata, 32'h0);
`endif
      // Randomised traffic, mostly short pulses and rare resets.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] d;
         d = $urandom;
         if ($urandom_range(0, 7) != 0) d[23:8] = 16'($urandom_range(0, 12));
         reset_n    = ($urandom_range(0, 149) != 0);
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 2) != 0);
         write_n    = ($urandom_range(0, 2) == 0);
         writedata  = d;
         tick();
      end
      reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
      tick();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
